// File: rtl/activity_led_bank.sv
// activity_led_bank: multi-channel activity indicator.
// Each channel synchronises an asynchronous activity input and detects
// toggles on it. The activity is shown on a registered LED output, either
// stretched to a fixed length or as a fixed-cadence blink. A per-channel
// force_on bit overrides the displayed activity.
module activity_led_bank #(
  parameter int    N_CHANNELS   = 4,
  parameter int    WIDTH        = 256,
  parameter logic  ACTIVE_LEVEL = 1'b0,
  parameter int    SYNC_STAGES  = 2,
  parameter string MODE         = "STRETCH"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CHANNELS-1:0] i,
  input  logic [N_CHANNELS-1:0] force_on,
  output logic [N_CHANNELS-1:0] o
);

  // Phase counter width; a one-cycle phase still needs a one-bit counter.
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LOAD = CW'(WIDTH - 1);

  // The warm-up counter must be able to hold SYNC_STAGES.
  localparam int             WW        = $clog2(SYNC_STAGES + 2);
  localparam logic [WW-1:0]  WARM_LAST = WW'(SYNC_STAGES);

  // Elaboration-time parameter sanity checks.
  if (N_CHANNELS < 1) begin : g_bad_channels
    $fatal(1, "activity_led_bank: N_CHANNELS must be at least 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "activity_led_bank: WIDTH must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "activity_led_bank: SYNC_STAGES must be at least 2");
  end

  logic [N_CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
  logic [N_CHANNELS-1:0]                  prev_q;
  logic [N_CHANNELS-1:0]                  sync_out;
  logic [N_CHANNELS-1:0]                  evt;
  logic [N_CHANNELS-1:0]                  act_next;
  logic [WW-1:0]                          warm_cnt;
  logic                                   primed;

  // Synchroniser chain plus the previous-value flop used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], i[k]};
        prev_q[k] <= sync_q[k][SYNC_STAGES-1];
      end
    end
  end

  // Shared warm-up: hold off event detection until the chains have flushed,
  // so a line sitting high through reset is not mistaken for a toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
      primed   <= 1'b0;
    end else if (!primed) begin
      if (warm_cnt == WARM_LAST) begin
        primed <= 1'b1;
      end else begin
        warm_cnt <= warm_cnt + WW'(1);
      end
    end
  end

  // Either edge of the synchronised input is an event once primed.
  always_comb begin
    for (int k = 0; k < N_CHANNELS; k++) begin
      sync_out[k] = sync_q[k][SYNC_STAGES-1];
    end
    evt = {N_CHANNELS{primed}} & (sync_out ^ prev_q);
  end

  if (MODE == "STRETCH") begin : g_stretch

    logic [N_CHANNELS-1:0][CW-1:0] cnt_q;
    logic [N_CHANNELS-1:0][CW-1:0] cnt_d;
    logic [N_CHANNELS-1:0]         act_q;
    logic [N_CHANNELS-1:0]         act_d;

    // Pulse stretch: every event reloads the count, activity ends when the
    // count has run down to zero.
    always_comb begin
      cnt_d = cnt_q;
      act_d = act_q;
      for (int k = 0; k < N_CHANNELS; k++) begin
        if (evt[k]) begin
          cnt_d[k] = LOAD;
          act_d[k] = 1'b1;
        end else if (act_q[k]) begin
          if (cnt_q[k] != '0) begin
            cnt_d[k] = cnt_q[k] - CW'(1);
          end else begin
            act_d[k] = 1'b0;
          end
        end
      end
    end

    // Stretch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        act_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        act_q <= act_d;
      end
    end

    assign act_next = act_d;

  end else if (MODE == "BLINK") begin : g_blink

    typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
    } state_t;

    state_t                        state_q [N_CHANNELS];
    state_t                        state_d [N_CHANNELS];
    logic [N_CHANNELS-1:0][CW-1:0] cnt_q;
    logic [N_CHANNELS-1:0][CW-1:0] cnt_d;
    logic [N_CHANNELS-1:0]         pend_q;
    logic [N_CHANNELS-1:0]         pend_d;

    // Blink cadence: ON and OFF phases of equal length; activity seen during
    // OFF earns exactly one more ON phase, activity during ON is dropped.
    always_comb begin
      cnt_d  = cnt_q;
      pend_d = pend_q;
      for (int k = 0; k < N_CHANNELS; k++) begin
        state_d[k] = state_q[k];
        case (state_q[k])
          IDLE: begin
            if (evt[k]) begin
              state_d[k] = ON;
              cnt_d[k]   = LOAD;
            end
          end
          ON: begin
            if (cnt_q[k] == '0) begin
              state_d[k] = OFF;
              cnt_d[k]   = LOAD;
            end else begin
              cnt_d[k] = cnt_q[k] - CW'(1);
            end
          end
          OFF: begin
            if (cnt_q[k] == '0) begin
              if (pend_q[k] || evt[k]) begin
                state_d[k] = ON;
                cnt_d[k]   = LOAD;
              end else begin
                state_d[k] = IDLE;
              end
              pend_d[k] = 1'b0;
            end else begin
              cnt_d[k] = cnt_q[k] - CW'(1);
              if (evt[k]) begin
                pend_d[k] = 1'b1;
              end
            end
          end
          default: begin
            state_d[k] = IDLE;
            pend_d[k]  = 1'b0;
          end
        endcase
        act_next[k] = (state_d[k] == ON);
      end
    end

    // Blink state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < N_CHANNELS; k++) begin
          state_q[k] <= IDLE;
        end
        cnt_q  <= '0;
        pend_q <= '0;
      end else begin
        for (int k = 0; k < N_CHANNELS; k++) begin
          state_q[k] <= state_d[k];
        end
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
      end
    end

  end else begin : g_bad_mode

    $fatal(1, "activity_led_bank: MODE must be \"STRETCH\" or \"BLINK\"");
    assign act_next = '0;

  end

  // Registered LED drive: force_on or the activity being entered this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o <= {N_CHANNELS{~ACTIVE_LEVEL}};
    end else begin
      for (int k = 0; k < N_CHANNELS; k++) begin
        o[k] <= (force_on[k] | act_next[k]) ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
      end
    end
  end

endmodule

// File: tb/tb_activity_led_bank.sv
// tb_activity_led_bank: drives a STRETCH and a BLINK instance side by side.
// Each scenario task pushes the LED pattern expected for an edge when it
// drives that edge's stimulus, then pops and compares once the edge is past.
module tb_activity_led_bank;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] i_s   = 2'b00;
  logic [1:0] f_s   = 2'b00;
  logic [1:0] o_s;
  logic [1:0] i_b   = 2'b00;
  logic [1:0] f_b   = 2'b00;
  logic [1:0] o_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q [$];

  always #5 clk = ~clk;

  activity_led_bank #(
    .N_CHANNELS  (2),
    .WIDTH       (4),
    .ACTIVE_LEVEL(1'b0),
    .SYNC_STAGES (2),
    .MODE        ("STRETCH")
  ) dut_stretch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i_s),
    .force_on(f_s),
    .o       (o_s)
  );

  activity_led_bank #(
    .N_CHANNELS  (2),
    .WIDTH       (4),
    .ACTIVE_LEVEL(1'b0),
    .SYNC_STAGES (2),
    .MODE        ("BLINK")
  ) dut_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i_b),
    .force_on(f_b),
    .o       (o_b)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // i[0] high through reset and release: both LEDs must stay off.
  task automatic test_reset();
    logic [1:0] exp;
    i_s = 2'b01;
    i_b = 2'b01;
    f_s = 2'b00;
    f_b = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_s !== 2'b11) $display("[TB] FAIL reset_async_stretch: o=%b expected 11", o_s);
    else n_pass++;
    n_checks++;
    if (o_b !== 2'b11) $display("[TB] FAIL reset_async_blink: o=%b expected 11", o_b);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      exp_q.push_back(2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp || o_b !== exp)
        $display("[TB] FAIL reset_hold cycle %0d: stretch o=%b blink o=%b expected %b", c, o_s, o_b, exp);
      else n_pass++;
    end
  endtask

  // One rising toggle on channel 0: LED on from E0+2 for four edges.
  task automatic test_single_pulse();
    logic [1:0] exp;
    i_s[0] = 1'b0;
    repeat (10) step();
    for (int c = 0; c < 8; c++) begin
      if (c == 0) i_s[0] = 1'b1;
      exp_q.push_back((c >= 2 && c <= 5) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp) $display("[TB] FAIL single_pulse E0+%0d: o=%b expected %b", c, o_s, exp);
      else n_pass++;
    end
  endtask

  // Toggles at E0 and E0+3: LED on continuously E0+2..E0+8.
  task automatic test_retrigger();
    logic [1:0] exp;
    for (int c = 0; c < 11; c++) begin
      if (c == 0 || c == 3) i_s[0] = ~i_s[0];
      exp_q.push_back((c >= 2 && c <= 8) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp) $display("[TB] FAIL retrigger E0+%0d: o=%b expected %b", c, o_s, exp);
      else n_pass++;
    end
  endtask

  // Second event lands on the expiry edge of the first: reload wins.
  task automatic test_stretch_expiry_event();
    logic [1:0] exp;
    for (int c = 0; c < 12; c++) begin
      if (c == 0 || c == 4) i_s[0] = ~i_s[0];
      exp_q.push_back((c >= 2 && c <= 9) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp) $display("[TB] FAIL expiry_reload E0+%0d: o=%b expected %b", c, o_s, exp);
      else n_pass++;
    end
  endtask

  // force_on[1] for three cycles on an idle channel.
  task automatic test_force();
    logic [1:0] exp;
    for (int c = 0; c < 5; c++) begin
      f_s = (c < 3) ? 2'b10 : 2'b00;
      exp_q.push_back((c < 3) ? 2'b01 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp) $display("[TB] FAIL force F0+%0d: o=%b expected %b", c, o_s, exp);
      else n_pass++;
    end
  endtask

  // Toggle every cycle for 40 cycles: 4 on / 4 off, one trailing ON from
  // the pending OFF-phase activity, then idle.
  task automatic test_blink_continuous();
    logic [1:0] exp;
    for (int c = 0; c < 53; c++) begin
      if (c < 40) i_b[0] = ~i_b[0];
      exp_q.push_back((c >= 2 && c <= 45 && ((c - 2) % 8) < 4) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_b !== exp) $display("[TB] FAIL blink_continuous E0+%0d: o=%b expected %b", c, o_b, exp);
      else n_pass++;
    end
  endtask

  // Extra toggles during ON, including its final edge, add no phase.
  task automatic test_blink_on_events();
    logic [1:0] exp;
    for (int c = 0; c < 21; c++) begin
      if (c == 0 || c == 2 || c == 4) i_b[0] = ~i_b[0];
      exp_q.push_back((c >= 2 && c <= 5) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_b !== exp) $display("[TB] FAIL blink_on_ignore E0+%0d: o=%b expected %b", c, o_b, exp);
      else n_pass++;
    end
  endtask

  // A second toggle at cycle t2 lands in OFF: exactly one further ON.
  task automatic test_blink_off_event(input int t2);
    logic [1:0] exp;
    for (int c = 0; c < 25; c++) begin
      if (c == 0 || c == t2) i_b[0] = ~i_b[0];
      exp_q.push_back(((c >= 2 && c <= 5) || (c >= 10 && c <= 13)) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_b !== exp) $display("[TB] FAIL blink_off_event t2=%0d E0+%0d: o=%b expected %b", t2, c, o_b, exp);
      else n_pass++;
    end
  endtask

  // Reset during a stretch, then inputs toggling through the warm-up.
  task automatic test_mid_reset();
    logic [1:0] exp;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) i_s[0] = ~i_s[0];
      exp_q.push_back((c == 2) ? 2'b10 : 2'b11);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp) $display("[TB] FAIL mid_reset_pre E0+%0d: o=%b expected %b", c, o_s, exp);
      else n_pass++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_s !== 2'b11 || o_b !== 2'b11)
      $display("[TB] FAIL mid_reset_async: stretch o=%b blink o=%b expected 11", o_s, o_b);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      i_s = ~i_s;
      step();
      n_checks++;
      if (o_s !== 2'b11) $display("[TB] FAIL mid_reset_held cycle %0d: o=%b expected 11", c, o_s);
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      i_s = ~i_s;
      exp_q.push_back((c <= 3) ? 2'b11 : 2'b00);
      step();
      exp = exp_q.pop_front();
      n_checks++;
      if (o_s !== exp || o_b !== 2'b11)
        $display("[TB] FAIL mid_reset_warmup R%0d: stretch o=%b expected %b, blink o=%b expected 11", c, o_s, exp, o_b);
      else n_pass++;
    end
    repeat (12) step();
    n_checks++;
    if (o_s !== 2'b11) $display("[TB] FAIL mid_reset_final: o=%b expected 11", o_s);
    else n_pass++;
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] activity_led_bank bench start");
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_stretch_expiry_event();
    test_force();
    test_blink_continuous();
    test_blink_on_events();
    test_blink_off_event(5);
    test_blink_off_event(8);
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
